// File: rtl/spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte transmitter, MSB first; receive path built only with SPI_BYTE_TX_RX_EN.
// Latency: frame starts on the START edge, CS_N low for 17*HALF_DIV cycles, DONE pulses on the closing edge.
// Backpressure: START ignored while BUSY; START during the DONE cycle launches the next frame back-to-back.
module spi_byte_tx #(
    parameter int HALF_DIV = 1
) (
    input  logic       CLK_1KHZ,
    input  logic       RESET,
    input  logic [7:0] DATA,
    input  logic       START,
`ifdef SPI_BYTE_TX_RX_EN
    input  logic       MISO,
    output logic [7:0] RX_DATA,
`endif
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_N,
    output logic       BUSY,
    output logic       DONE
);

    // Zero is treated as one; anything above the counter range saturates.
    localparam int         HD_EFF     = (HALF_DIV < 1) ? 1 : ((HALF_DIV > 255) ? 255 : HALF_DIV);
    localparam logic [7:0] CNT_RELOAD = 8'(HD_EFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_n;
    logic [7:0] shreg;
    logic [7:0] shreg_n;
    logic       sclk_n;
    logic       mosi_n;
    logic       cs_n_n;
    logic       busy_n;
    logic       done_n;
`ifdef SPI_BYTE_TX_RX_EN
    logic       rx_shift;
    logic       rx_load;
    logic [7:0] rx_shreg;
`endif

    always_ff @(posedge CLK_1KHZ) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            CS_N    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            SCLK    <= sclk_n;
            MOSI    <= mosi_n;
            CS_N    <= cs_n_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        sclk_n    = SCLK;
        mosi_n    = MOSI;
        cs_n_n    = CS_N;
        busy_n    = BUSY;
        done_n    = 1'b0;
`ifdef SPI_BYTE_TX_RX_EN
        rx_shift  = 1'b0;
        rx_load   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    state_n   = SETUP;
                    cnt_n     = CNT_RELOAD;
                    bit_idx_n = 3'd7;
                    shreg_n   = DATA;
                    mosi_n    = DATA[7];
                    cs_n_n    = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_n  = SHIFT_HI;
                    cnt_n    = CNT_RELOAD;
                    sclk_n   = 1'b1;
`ifdef SPI_BYTE_TX_RX_EN
                    rx_shift = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt == 8'd0) begin
                    cnt_n  = CNT_RELOAD;
                    sclk_n = 1'b0;
                    if (bit_idx == 3'd0) begin
                        state_n = HOLD;
                    end else begin
                        // Rotate so the next lower bit sits at [7]; the bit leaving is no longer needed.
                        state_n   = SHIFT_LO;
                        bit_idx_n = bit_idx - 3'd1;
                        mosi_n    = shreg[6];
                        shreg_n   = {shreg[6:0], shreg[7]};
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SHIFT_LO: begin
                if (cnt == 8'd0) begin
                    state_n  = SHIFT_HI;
                    cnt_n    = CNT_RELOAD;
                    sclk_n   = 1'b1;
`ifdef SPI_BYTE_TX_RX_EN
                    rx_shift = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = '0;
                    sclk_n    = 1'b0;
                    mosi_n    = 1'b0;
                    cs_n_n    = 1'b1;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
`ifdef SPI_BYTE_TX_RX_EN
                    rx_load   = 1'b1;
`endif
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sclk_n  = 1'b0;
                mosi_n  = 1'b0;
                cs_n_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

`ifdef SPI_BYTE_TX_RX_EN
    // MISO is captured on the same edges that raise SCLK, i.e. the slave's mode-0 sample point.
    always_ff @(posedge CLK_1KHZ) begin
        if (!RESET) begin
            rx_shreg <= '0;
            RX_DATA  <= '0;
        end else begin
            if (rx_shift) begin
                rx_shreg <= {rx_shreg[6:0], MISO};
            end
            if (rx_load) begin
                RX_DATA <= rx_shreg;
            end
        end
    end
`endif

endmodule

// File: doc/spi_byte_tx.md
SPI_BYTE_TX -- requirements
Module: spi_byte_tx

Interface
REQ-001 Parameter HALF_DIV, default 1: SCLK half-period in CLK_1KHZ cycles; legal range 1..255; a value of 0 SHALL behave as 1.
REQ-002 CLK_1KHZ  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset (0 = reset, sampled on the CLK_1KHZ rising edge).
REQ-004 DATA  input  8  byte to transmit; sampled only on the accepting edge.
REQ-005 START  input  1  transfer request; level-sampled in IDLE.
REQ-006 SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 MOSI  output  1  serial data, MSB first.
REQ-008 CS_N  output  1  active-low chip select.
REQ-009 BUSY  output  1  high while a frame is in progress.
REQ-010 DONE  output  1  one-cycle pulse at frame end.
REQ-011 All outputs SHALL be registered.

Function
REQ-012 States SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO and HOLD, with an 8-bit half-period counter and a 3-bit bit index.
REQ-013 IDLE: on START=1, the block SHALL latch DATA into the shift register, enter SETUP, drive CS_N=0, drive MOSI=DATA[7] and set BUSY=1 on the same edge.
REQ-014 SETUP SHALL last HALF_DIV cycles with SCLK=0 and then enter SHIFT_HI.
REQ-015 SHIFT_HI SHALL last HALF_DIV cycles with SCLK=1, and MOSI SHALL be held stable.
REQ-016 Leaving SHIFT_HI after bits 7..1, the block SHALL enter SHIFT_LO with SCLK=0 and MOSI set to the next lower bit.
REQ-017 Leaving SHIFT_HI after bit 0, the block SHALL enter HOLD instead of SHIFT_LO.
REQ-018 SHIFT_LO SHALL last HALF_DIV cycles and then enter SHIFT_HI.
REQ-019 HOLD SHALL last HALF_DIV cycles with SCLK=0 and CS_N=0, and then enter IDLE.
REQ-020 Frame timing: CS_N low for exactly 17*HALF_DIV cycles; exactly 8 SCLK rising edges; SCLK=0 whenever CS_N=1.
REQ-021 On the HOLD->IDLE edge, the block SHALL set CS_N=1, BUSY=0, DONE=1 and MOSI=0; DONE SHALL be high for exactly one cycle.
REQ-022 START while BUSY=1 SHALL be ignored (no queueing), and DATA changes during a frame SHALL NOT affect it.
REQ-023 START=1 during the DONE cycle SHALL be accepted, giving back-to-back frames with exactly 1 cycle of CS_N high between them.
REQ-024 The half-period counter SHALL count HALF_DIV-1 down to 0 and reload on every state transition; it SHALL never wrap through 255.

Reset
REQ-025 While RESET=0 at a clock edge, the block SHALL load state=IDLE, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0 and clear the counter, bit index and shift register.
REQ-026 Reset mid-frame SHALL abort the frame without a DONE pulse, and SHALL take priority over START on the same edge.
REQ-027 The first transfer SHALL be accepted on the first edge with RESET=1 and START=1.

Configuration
REQ-028 Macro SPI_BYTE_TX_RX_EN defined: add input MISO (1 bit) and output RX_DATA (8 bits, registered).
REQ-029 With the macro defined, MISO SHALL be sampled on each SETUP->SHIFT_HI and SHIFT_LO->SHIFT_HI edge and shifted in MSB first.
REQ-030 With the macro defined, RX_DATA SHALL update to the assembled byte on the DONE edge and hold its value otherwise; its reset value SHALL be 0x00.
REQ-031 Macro not defined: MISO and RX_DATA SHALL be absent and no receive logic SHALL be synthesised; TX behaviour SHALL be identical in both builds.

Verification
REQ-032 HALF_DIV=1, DATA=0xA5, START pulsed 1 cycle -> MOSI sampled at the 8 SCLK rises = 1,0,1,0,0,1,0,1; CS_N low 17 cycles; one DONE pulse; BUSY high for 17 cycles.
REQ-033 HALF_DIV=3, DATA=0x81 -> SCLK high and low phases 3 cycles each; CS_N low 51 cycles; DATA changed to 0x00 mid-frame does not alter MOSI.
REQ-034 START held high, DATA=0x3C then 0xC3 -> two frames with CS_N high for exactly 1 cycle between them; second frame sends 0xC3; one DONE per frame.
REQ-035 RESET=0 asserted at the 4th SCLK rise -> next edge CS_N=1, SCLK=0, MOSI=0, BUSY=0; no DONE; a new START then sends a full 8-bit frame.
REQ-036 SPI_BYTE_TX_RX_EN defined, MISO looped to MOSI, DATA=0x5A -> RX_DATA=0x5A on the DONE cycle; with MISO tied to 1 -> RX_DATA=0xFF.
REQ-037 HALF_DIV=0 -> timing identical to the HALF_DIV=1 case in REQ-032.
